// File: rtl/alu_sequencer_if.sv
// Request handshake between an issuing master and the ALU sequencer.
// WIDTH must match the sequencer it connects to.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  modport master (output req_valid, req_op, req_a, req_b, input req_ready);
  modport slave  (input req_valid, req_op, req_a, req_b, output req_ready);
endinterface

// File: rtl/alu_sequencer.sv
// Issue-side controller for the combinational ALU: latches a request, drives the ALU,
// owns the ZF/NF/CF/OF flag register and unrolls multi-step shifts into repeated passes.
//
// state | meaning
// IDLE  | ready for a request; external flag writes accepted
// ISSUE | ALU pass(es) in flight; rep_cnt counts remaining passes (0 = single-step op)
// DONE  | one-cycle done pulse, result/flags valid
module alu_sequencer #(
  parameter int         WIDTH    = 16,
  parameter int         REP_BITS = 5,
  parameter logic [4:0] M_FIRST  = 5'd16,
  parameter logic [4:0] M_LAST   = 5'd23,
  parameter logic [4:0] M_OFFSET = 5'd8
) (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   req,
  input  logic             flags_we,
  input  logic [3:0]       flags_wdata,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [4:0]       alu_opsel,
  output logic [3:0]       alu_flags,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_ready,
  input  logic [3:0]       alu_flag_next,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [REP_BITS-1:0] rep_cnt;
  logic [REP_BITS-1:0] req_count;
  logic                req_multi;

  assign req_count     = req.req_b[REP_BITS-1:0];
  assign req_multi     = (req.req_op >= M_FIRST) && (req.req_op <= M_LAST);
  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign alu_flags     = flags;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rep_cnt   <= '0;
      alu_srcA  <= '0;
      alu_srcB  <= '0;
      alu_opsel <= '0;
      result    <= '0;
      flags     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (flags_we) flags <= flags_wdata;
          if (req.req_valid) begin
            if (!req_multi) begin
              alu_srcA  <= req.req_a;
              alu_srcB  <= req.req_b;
              alu_opsel <= req.req_op;
              rep_cnt   <= '0;
              state     <= ISSUE;
            end else if (req_count == '0) begin
              // zero repeat count: operand passes straight through, flags untouched
              result <= req.req_a;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              alu_srcA  <= req.req_a;
              alu_srcB  <= WIDTH'(1);
              alu_opsel <= req.req_op + M_OFFSET;
              rep_cnt   <= req_count;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (alu_ready) begin
            flags <= alu_flag_next;
            if (rep_cnt != '0) begin
              alu_srcA <= alu_res;
              rep_cnt  <= rep_cnt - REP_BITS'(1);
            end
            if (rep_cnt <= REP_BITS'(1)) begin
              result <= alu_res;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a small ALU model services the DUT, the stimulus
// queues hand-computed results and a negedge monitor scores every done pulse.
module tb_alu_sequencer;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flags_we;
  logic [3:0]       flags_wdata;
  logic [WIDTH-1:0] alu_srcA, alu_srcB, alu_res, result;
  logic [4:0]       alu_opsel;
  logic [3:0]       alu_flags, alu_flag_next, flags;
  logic             alu_ready, done, busy;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer_if #(.WIDTH(WIDTH)) req_if ();

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req_if),
    .flags_we     (flags_we),
    .flags_wdata  (flags_wdata),
    .alu_srcA     (alu_srcA),
    .alu_srcB     (alu_srcB),
    .alu_opsel    (alu_opsel),
    .alu_flags    (alu_flags),
    .alu_res      (alu_res),
    .alu_ready    (alu_ready),
    .alu_flag_next(alu_flag_next),
    .done         (done),
    .result       (result),
    .flags        (flags),
    .busy         (busy)
  );

  // ALU model: 0 ADD, 1 SUB, 2 ADC, 24 RSL (logical shift right by srcB[3:0])
  logic [16:0] sum;
  always_comb begin
    sum           = '0;
    alu_res       = '0;
    alu_flag_next = '0;
    case (alu_opsel)
      5'd0, 5'd2: begin
        sum = {1'b0, alu_srcA} + {1'b0, alu_srcB} + ((alu_opsel == 5'd2) ? {16'd0, alu_flags[1]} : 17'd0);
        alu_res          = sum[15:0];
        alu_flag_next[1] = sum[16];
        alu_flag_next[0] = (alu_srcA[15] == alu_srcB[15]) && (sum[15] != alu_srcA[15]);
      end
      5'd1: begin
        alu_res          = alu_srcA - alu_srcB;
        alu_flag_next[1] = alu_srcA < alu_srcB;
        alu_flag_next[0] = (alu_srcA[15] != alu_srcB[15]) && (alu_res[15] != alu_srcA[15]);
      end
      5'd24: begin
        alu_res          = alu_srcA >> alu_srcB[3:0];
        alu_flag_next[1] = (alu_srcB[3:0] != 4'd0) ? alu_srcA[alu_srcB[3:0] - 4'd1] : 1'b0;
      end
      default: alu_res = '0;
    endcase
    alu_flag_next[3] = (alu_res == '0);
    alu_flag_next[2] = alu_res[15];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("flags", {28'd0, flags}, {28'd0, e.flg});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (req_if.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", sb_q.size(), 32'd0);
  endtask

  // Returns at #1 after the accepting edge; acc is the cycle stamp of that edge.
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [3:0] ef, input int off,
                       input bit push, output int acc);
    wait_idle();
    req_if.req_valid = 1'b1;
    req_if.req_op    = op;
    req_if.req_a     = a;
    req_if.req_b     = b;
    @(posedge clk);
    #1;
    acc = cyc;
    req_if.req_valid = 1'b0;
    if (push) sb_q.push_back('{er, ef, acc + off});
  endtask

  initial begin
    int acc;
    logic [15:0] seq [3];
    seq = '{16'h8000, 16'h4000, 16'h2000};
    req_if.req_valid = 1'b0;
    req_if.req_op    = '0;
    req_if.req_a     = '0;
    req_if.req_b     = '0;
    flags_we    = 1'b0;
    flags_wdata = '0;
    alu_ready   = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, req_if.req_ready}, 32'd1);
    chk("rst_srcA", {16'd0, alu_srcA}, 32'd0);
    chk("rst_srcB", {16'd0, alu_srcB}, 32'd0);
    chk("rst_opsel", {27'd0, alu_opsel}, 32'd0);
    rst = 1'b1;

    issue(5'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1, 1'b1, acc);
    wait_drain();

    issue(5'd24, 16'h8000, 16'h0003, 16'h1000, 4'b0000, 1, 1'b1, acc);
    wait_drain();
    issue(5'd16, 16'h8000, 16'h0003, 16'h1000, 4'b0000, 3, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("multi_opsel", {27'd0, alu_opsel}, 32'd24);
      chk("multi_srcB", {16'd0, alu_srcB}, 32'd1);
      chk("multi_srcA", {16'd0, alu_srcA}, {16'd0, seq[i]});
    end
    wait_drain();

    issue(5'd16, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 0, 1'b1, acc);
    wait_drain();

    alu_ready = 1'b0;
    issue(5'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 4, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_opsel", {27'd0, alu_opsel}, 32'd1);
      chk("stall_srcA", {16'd0, alu_srcA}, 32'd0);
      chk("stall_srcB", {16'd0, alu_srcB}, 32'd1);
      chk("stall_flags", {28'd0, flags}, 32'd0);
      chk("stall_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1 alu_ready = 1'b1;
    wait_drain();

    wait_idle();
    flags_we    = 1'b1;
    flags_wdata = 4'hF;
    @(posedge clk);
    #1 flags_we = 1'b0;
    @(negedge clk);
    chk("flags_we_idle", {28'd0, flags}, 32'hF);

    alu_ready = 1'b0;
    issue(5'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 2, 1'b1, acc);
    flags_we    = 1'b1;
    flags_wdata = 4'h3;
    @(posedge clk);
    #1 flags_we = 1'b0;
    @(negedge clk);
    chk("flags_we_issue_ignored", {28'd0, flags}, 32'hF);
    alu_ready = 1'b1;
    wait_drain();

    issue(5'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1, 1'b1, acc);
    req_if.req_valid = 1'b1;
    req_if.req_op    = 5'd0;
    req_if.req_a     = 16'h0010;
    req_if.req_b     = 16'h0020;
    sb_q.push_back('{16'h0030, 4'b0000, acc + 4});
    @(negedge clk);
    chk("busy_ready_issue", {31'd0, req_if.req_ready}, 32'd0);
    chk("busy_no_latch", {16'd0, alu_srcA}, 32'h2);
    @(negedge clk);
    chk("busy_ready_done", {31'd0, req_if.req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_back_idle", {31'd0, req_if.req_ready}, 32'd1);
    @(posedge clk);
    #1 req_if.req_valid = 1'b0;
    wait_drain();

    flags_we    = 1'b1;
    flags_wdata = 4'b0010;
    issue(5'd2, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 1, 1'b1, acc);
    flags_we = 1'b0;
    wait_drain();

    issue(5'd16, 16'h8001, 16'h0005, 16'h0000, 4'b0000, 0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    chk("pass2_srcA", {16'd0, alu_srcA}, 32'h4000);
    chk("pass1_flags", {28'd0, flags}, 32'b0010);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, req_if.req_ready}, 32'd1);
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_flags", {28'd0, flags}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_opsel", {27'd0, alu_opsel}, 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
